id_stage_hz: RTL and testbench

Parametrised MIPS instruction-decode stage: register file with debug port and write-through bypass, main control decode, sign extension, and a registered ID/EX pipeline boundary. Adds load-use hazard detection (stall) and flush/bubble insertion. Sits between the IF/ID register and EX; writeback feeds back into it, and the debug unit reads and writes the register file through it.

---
 rtl/id_stage_hz_pkg.sv | 74 +++++++
 rtl/id_stage_hz_reg_file.sv | 73 +++++++
 rtl/id_stage_hz.sv | 187 ++++++++++++++++++
 tb/tb_id_stage_hz.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_hz_pkg.sv
// Shared decode definitions for the MIPS instruction-decode stage.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: opcode/funct encodings, the control bundle carried into EX,
// the NOP bundle used for bubbles, and helpers for decode and hazard checks.
package id_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes, instruction bits [5:0]; passed through to the ALU control
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic reg_dst;
    logic branch;
    logic illegal;
  } ctrl_t;

  // Bubble bundle: nothing is written, nothing is flagged illegal
  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
      end
      default: begin
        c.illegal = 1'b1;
      end
    endcase
    return c;
  endfunction

  // Only these opcodes consume rt as a source; ADDI/LW use it as a destination,
  // so a load-use match on rt must not stall them.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_stage_hz_reg_file.sv
// Register file: two operand read ports with writeback bypass, one debug read port,
// one write port where a debug write beats writeback. Reads are combinational,
// writes land at the clock edge; no backpressure (always accepts).
// Ports: i_clk/i_reset (sync, active-high, clears every entry); i_rs_addr/i_rt_addr ->
// o_rs_data/o_rt_data; i_dbg_addr -> o_dbg_rdata; i_dbg_wr/i_dbg_wdata debug write;
// i_wb_en/i_wb_addr/i_wb_data writeback; i_debug_mode blocks writeback.
module id_reg_file #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_REG-1:0]  i_rs_addr,
  input  logic [NB_REG-1:0]  i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic               i_debug_mode,
  input  logic               i_dbg_wr,
  input  logic [NB_REG-1:0]  i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  input  logic               i_wb_en,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data
);

  localparam int unsigned NR = N_REGS;

  logic [NB_DATA-1:0] regs_q [N_REGS];

  // Entry 0 is hardwired to zero; addresses past N_REGS don't exist and read as zero.
  function automatic logic writable(input logic [NB_REG-1:0] a);
    return (a != '0) && (32'(a) < NR);
  endfunction

  function automatic logic [NB_DATA-1:0] rd(input logic [NB_REG-1:0] a,
                                            input logic [NB_DATA-1:0] v);
    return writable(a) ? v : '0;
  endfunction

  logic dbg_wr_en;
  logic wb_wr_en;
  logic wb_hit_en;

  assign dbg_wr_en = i_debug_mode && i_dbg_wr && writable(i_dbg_addr);
  assign wb_wr_en  = !i_debug_mode && i_wb_en && writable(i_wb_addr);
  // Bypass is independent of debug mode: in debug mode ID/EX holds, so the
  // forwarded value is never captured anyway.
  assign wb_hit_en = i_wb_en && (i_wb_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < N_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (dbg_wr_en) begin
      regs_q[i_dbg_addr] <= i_dbg_wdata;
    end else if (wb_wr_en) begin
      regs_q[i_wb_addr] <= i_wb_data;
    end
  end

  always_comb begin
    o_rs_data   = rd(i_rs_addr, regs_q[i_rs_addr]);
    o_rt_data   = rd(i_rt_addr, regs_q[i_rt_addr]);
    o_dbg_rdata = rd(i_dbg_addr, regs_q[i_dbg_addr]);
    // Write-through: a writeback in this cycle is visible to this cycle's decode.
    if (wb_hit_en && (i_wb_addr == i_rs_addr)) o_rs_data = i_wb_data;
    if (wb_hit_en && (i_wb_addr == i_rt_addr)) o_rt_data = i_wb_data;
  end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS instruction decode: register read with bypass, control decode, sign extension,
// load-use hazard detection and a registered ID/EX boundary. Latency: 1 cycle.
// Backpressure: o_stall (combinational) holds PC and IF/ID for one cycle on load-use.
// Ports: IF/ID in (i_valid, i_pc, i_instruction, i_flush); writeback in (i_wb_*);
// debug (i_debug_mode, i_dbg_*, o_dbg_rdata); ID/EX out (o_valid, o_pc, operands,
// register fields, funct, immediate, controls, o_illegal) and o_stall.
module id_stage_hz
  import id_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_flush,
  input  logic               i_wb_en,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_debug_mode,
  input  logic               i_dbg_we,
  input  logic [NB_REG-1:0]  i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_stall,
  output logic               o_valid,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [5:0]         o_funct,
  output logic [NB_DATA-1:0] o_sign_extend,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic               o_reg_dst,
  output logic               o_branch,
  output logic               o_illegal
);

  // ---------------- instruction fields ----------------
  logic [5:0]         opcode;
  logic [NB_REG-1:0]  rs;
  logic [NB_REG-1:0]  rt;
  logic [NB_REG-1:0]  rd;
  logic [5:0]         funct;
  logic [15:0]        imm;
  logic [NB_DATA-1:0] sext;
  logic               unused_shamt;

  assign opcode       = i_instruction[31:26];
  assign rs           = NB_REG'(i_instruction[25:21]);
  assign rt           = NB_REG'(i_instruction[20:16]);
  assign rd           = NB_REG'(i_instruction[15:11]);
  assign funct        = i_instruction[5:0];
  assign imm          = i_instruction[15:0];
  assign sext         = NB_DATA'($signed(imm));
  assign unused_shamt = ^i_instruction[10:6];

  // ---------------- register file ----------------
  logic [NB_DATA-1:0] rs_data;
  logic [NB_DATA-1:0] rt_data;

  id_reg_file #(
    .NB_DATA (NB_DATA),
    .NB_REG  (NB_REG),
    .N_REGS  (N_REGS)
  ) u_reg_file (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rs_addr    (rs),
    .i_rt_addr    (rt),
    .o_rs_data    (rs_data),
    .o_rt_data    (rt_data),
    .i_debug_mode (i_debug_mode),
    .i_dbg_wr     (i_dbg_we),
    .i_dbg_addr   (i_dbg_addr),
    .i_dbg_wdata  (i_dbg_wdata),
    .o_dbg_rdata  (o_dbg_rdata),
    .i_wb_en      (i_wb_en),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data)
  );

  // ---------------- ID/EX state ----------------
  logic               valid_q, valid_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] data_1_q, data_1_d;
  logic [NB_DATA-1:0] data_2_q, data_2_d;
  logic [NB_REG-1:0]  rs_q, rs_d;
  logic [NB_REG-1:0]  rt_q, rt_d;
  logic [NB_REG-1:0]  rd_q, rd_d;
  logic [5:0]         funct_q, funct_d;
  logic [NB_DATA-1:0] sext_q, sext_d;
  ctrl_t              ctrl_q, ctrl_d;

  // ---------------- load-use hazard ----------------
  // The load in EX can't forward until MEM; one bubble is enough because the
  // bubble itself clears mem_read, so the stall self-terminates.
  logic rs_match;
  logic rt_match;

  assign rs_match = (rt_q == rs);
  assign rt_match = (rt_q == rt) && reads_rt(opcode);

  assign o_stall = i_valid && valid_q && ctrl_q.mem_read && (rt_q != '0)
                && (rs_match || rt_match) && !i_flush && !i_debug_mode;

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    data_1_d = '0;
    data_2_d = '0;
    rs_d     = '0;
    rt_d     = '0;
    rd_d     = '0;
    funct_d  = '0;
    sext_d   = '0;
    ctrl_d   = CTRL_NOP;
    if (i_valid && !i_flush && !o_stall) begin
      valid_d  = 1'b1;
      pc_d     = i_pc;
      data_1_d = rs_data;
      data_2_d = rt_data;
      rs_d     = rs;
      rt_d     = rt;
      rd_d     = rd;
      funct_d  = funct;
      sext_d   = sext;
      ctrl_d   = decode_ctrl(opcode);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      data_1_q <= '0;
      data_2_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      funct_q  <= '0;
      sext_q   <= '0;
      ctrl_q   <= CTRL_NOP;
    end else if (!i_debug_mode) begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      data_1_q <= data_1_d;
      data_2_q <= data_2_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      funct_q  <= funct_d;
      sext_q   <= sext_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_pc          = pc_q;
  assign o_data_1      = data_1_q;
  assign o_data_2      = data_2_q;
  assign o_rs          = rs_q;
  assign o_rt          = rt_q;
  assign o_rd          = rd_q;
  assign o_funct       = funct_q;
  assign o_sign_extend = sext_q;
  assign o_reg_write   = ctrl_q.reg_write;
  assign o_mem_read    = ctrl_q.mem_read;
  assign o_mem_write   = ctrl_q.mem_write;
  assign o_mem_to_reg  = ctrl_q.mem_to_reg;
  assign o_alu_src     = ctrl_q.alu_src;
  assign o_reg_dst     = ctrl_q.reg_dst;
  assign o_branch      = ctrl_q.branch;
  assign o_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_instruction;
  logic        i_flush;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_debug_mode;
  logic        i_dbg_we;
  logic [4:0]  i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic [31:0] o_dbg_rdata;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_data_1;
  logic [31:0] o_data_2;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [5:0]  o_funct;
  logic [31:0] o_sign_extend;
  logic        o_reg_write;
  logic        o_mem_read;
  logic        o_mem_write;
  logic        o_mem_to_reg;
  logic        o_alu_src;
  logic        o_reg_dst;
  logic        o_branch;
  logic        o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-encoded instructions
  localparam logic [31:0] ADD_3_1_2  = 32'h0022_1820; // add r3,r1,r2
  localparam logic [31:0] ADDI_5_0   = 32'h2005_FFFC; // addi r5,r0,0xFFFC
  localparam logic [31:0] LW_4_1     = 32'h8C24_0000; // lw r4,0(r1)
  localparam logic [31:0] ADD_6_4_2  = 32'h0082_3020; // add r6,r4,r2
  localparam logic [31:0] ADDI_7_0   = 32'h2007_0001; // addi r7,r0,1
  localparam logic [31:0] ADD_3_0_0  = 32'h0000_1820; // add r3,r0,r0
  localparam logic [31:0] ILLEGAL    = 32'hFC00_0000; // opcode 111111
  localparam logic [31:0] SW_2_4_1   = 32'hAC22_0004; // sw r2,4(r1)

  id_stage_hz #(
    .NB_ADDR (32),
    .NB_INST (32),
    .NB_DATA (32),
    .NB_REG  (5),
    .N_REGS  (32)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_instruction (i_instruction),
    .i_flush       (i_flush),
    .i_wb_en       (i_wb_en),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_debug_mode  (i_debug_mode),
    .i_dbg_we      (i_dbg_we),
    .i_dbg_addr    (i_dbg_addr),
    .i_dbg_wdata   (i_dbg_wdata),
    .o_dbg_rdata   (o_dbg_rdata),
    .o_stall       (o_stall),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_data_1      (o_data_1),
    .o_data_2      (o_data_2),
    .o_rs          (o_rs),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_funct       (o_funct),
    .o_sign_extend (o_sign_extend),
    .o_reg_write   (o_reg_write),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_mem_to_reg  (o_mem_to_reg),
    .o_alu_src     (o_alu_src),
    .o_reg_dst     (o_reg_dst),
    .o_branch      (o_branch),
    .o_illegal     (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    i_reset       = 1'b1;
    i_valid       = 1'b0;
    i_pc          = '0;
    i_instruction = '0;
    i_flush       = 1'b0;
    i_wb_en       = 1'b0;
    i_wb_addr     = '0;
    i_wb_data     = '0;
    i_debug_mode  = 1'b0;
    i_dbg_we      = 1'b0;
    i_dbg_addr    = 5'd1;
    i_dbg_wdata   = '0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", o_valid, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_data_1", o_data_1, 0);
    chk("rst_reg_write", o_reg_write, 0);
    chk("rst_illegal", o_illegal, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_dbg_rdata", o_dbg_rdata, 0);
    i_reset = 1'b0;

    // Debug writes r1=7, r2=8
    i_debug_mode = 1'b1;
    i_dbg_we     = 1'b1;
    i_dbg_addr   = 5'd1;
    i_dbg_wdata  = 32'd7;
    tick();
    i_dbg_addr   = 5'd2;
    i_dbg_wdata  = 32'd8;
    tick();
    i_dbg_we     = 1'b0;
    i_dbg_addr   = 5'd1;
    settle();
    chk("dbg_read_r1", o_dbg_rdata, 32'd7);
    i_debug_mode = 1'b0;

    // ADD r3,r1,r2
    i_valid       = 1'b1;
    i_pc          = 32'h100;
    i_instruction = ADD_3_1_2;
    settle();
    chk("add_no_stall", o_stall, 0);
    tick();
    chk("add_valid", o_valid, 1);
    chk("add_pc", o_pc, 32'h100);
    chk("add_data_1", o_data_1, 32'd7);
    chk("add_data_2", o_data_2, 32'd8);
    chk("add_rd", o_rd, 3);
    chk("add_reg_write", o_reg_write, 1);
    chk("add_reg_dst", o_reg_dst, 1);
    chk("add_funct", o_funct, 6'h20);
    chk("add_alu_src", o_alu_src, 0);

    // ADDI r5,r0,0xFFFC
    i_pc          = 32'h104;
    i_instruction = ADDI_5_0;
    tick();
    chk("addi_sext", o_sign_extend, 32'hFFFF_FFFC);
    chk("addi_alu_src", o_alu_src, 1);
    chk("addi_rt", o_rt, 5);
    chk("addi_reg_dst", o_reg_dst, 0);
    chk("addi_reg_write", o_reg_write, 1);

    // LW r4,0(r1) followed by dependent ADD r6,r4,r2
    i_pc          = 32'h108;
    i_instruction = LW_4_1;
    tick();
    chk("lw_mem_read", o_mem_read, 1);
    chk("lw_mem_to_reg", o_mem_to_reg, 1);
    chk("lw_rt", o_rt, 4);
    chk("lw_data_1", o_data_1, 32'd7);
    i_pc          = 32'h10C;
    i_instruction = ADD_6_4_2;
    settle();
    chk("lu_stall", o_stall, 1);
    tick();
    chk("lu_bubble_valid", o_valid, 0);
    chk("lu_bubble_reg_write", o_reg_write, 0);
    chk("lu_bubble_mem_read", o_mem_read, 0);
    chk("lu_stall_cleared", o_stall, 0);
    tick();
    chk("lu_issue_valid", o_valid, 1);
    chk("lu_issue_rd", o_rd, 6);
    chk("lu_issue_pc", o_pc, 32'h10C);

    // LW r4 then independent ADDI r7,r0,1: no stall
    i_pc          = 32'h110;
    i_instruction = LW_4_1;
    tick();
    i_pc          = 32'h114;
    i_instruction = ADDI_7_0;
    settle();
    chk("addi_after_lw_no_stall", o_stall, 0);
    tick();
    chk("addi_after_lw_valid", o_valid, 1);
    chk("addi_after_lw_rt", o_rt, 7);

    // Writeback bypass on rt
    i_pc          = 32'h118;
    i_instruction = ADD_3_1_2;
    i_wb_en       = 1'b1;
    i_wb_addr     = 5'd2;
    i_wb_data     = 32'h55;
    tick();
    chk("bypass_data_2", o_data_2, 32'h55);
    chk("bypass_data_1", o_data_1, 32'd7);
    i_wb_en    = 1'b0;
    i_dbg_addr = 5'd2;
    settle();
    chk("wb_stored_r2", o_dbg_rdata, 32'h55);

    // Writeback to r0 has no effect
    i_pc          = 32'h11C;
    i_instruction = ADD_3_0_0;
    i_wb_en       = 1'b1;
    i_wb_addr     = 5'd0;
    i_wb_data     = 32'h99;
    tick();
    chk("r0_data_1", o_data_1, 0);
    chk("r0_data_2", o_data_2, 0);
    i_wb_en    = 1'b0;
    i_dbg_addr = 5'd0;
    settle();
    chk("r0_dbg_read", o_dbg_rdata, 0);

    // Flush overrides the load-use stall
    i_pc          = 32'h120;
    i_instruction = LW_4_1;
    tick();
    i_pc          = 32'h124;
    i_instruction = ADD_6_4_2;
    i_flush       = 1'b1;
    settle();
    chk("flush_no_stall", o_stall, 0);
    tick();
    chk("flush_bubble_valid", o_valid, 0);
    chk("flush_bubble_reg_write", o_reg_write, 0);
    i_flush = 1'b0;

    // Illegal opcode
    i_pc          = 32'h128;
    i_instruction = ILLEGAL;
    tick();
    chk("ill_valid", o_valid, 1);
    chk("ill_flag", o_illegal, 1);
    chk("ill_controls", {o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                         o_alu_src, o_reg_dst, o_branch}, 0);

    // SW r2,4(r1)
    i_pc          = 32'h12C;
    i_instruction = SW_2_4_1;
    tick();
    chk("sw_mem_write", o_mem_write, 1);
    chk("sw_alu_src", o_alu_src, 1);
    chk("sw_reg_write", o_reg_write, 0);
    chk("sw_sext", o_sign_extend, 32'd4);
    chk("sw_illegal", o_illegal, 0);

    // Debug mode holds ID/EX; debug write beats a simultaneous writeback
    i_debug_mode  = 1'b1;
    i_pc          = 32'h200;
    i_instruction = ADD_3_1_2;
    i_dbg_we      = 1'b1;
    i_dbg_addr    = 5'd3;
    i_dbg_wdata   = 32'hAA;
    i_wb_en       = 1'b1;
    i_wb_addr     = 5'd3;
    i_wb_data     = 32'hBB;
    tick();
    chk("dbg_hold_pc", o_pc, 32'h12C);
    chk("dbg_hold_mem_write", o_mem_write, 1);
    chk("dbg_hold_reg_dst", o_reg_dst, 0);
    i_dbg_we = 1'b0;
    i_wb_en  = 1'b0;
    settle();
    chk("dbg_wins_r3", o_dbg_rdata, 32'hAA);
    tick();
    chk("dbg_hold_pc_2", o_pc, 32'h12C);
    i_debug_mode = 1'b0;

    // Reset in the middle of a stall
    i_pc          = 32'h130;
    i_instruction = LW_4_1;
    tick();
    i_pc          = 32'h134;
    i_instruction = ADD_6_4_2;
    settle();
    chk("pre_reset_stall", o_stall, 1);
    i_reset = 1'b1;
    tick();
    chk("reset_clears_stall", o_stall, 0);
    chk("reset_clears_valid", o_valid, 0);
    chk("reset_clears_mem_read", o_mem_read, 0);
    i_dbg_addr = 5'd1;
    settle();
    chk("reset_clears_r1", o_dbg_rdata, 0);
    i_reset = 1'b0;
    i_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
